// File: rtl/expu_pkg.sv
// Shared definitions for the expu datapath: float layout, exponent bias,
// the +inf encoding and the accumulator FSM state type.
package expu_pkg;

    localparam int EXP_BITS   = 8;
    localparam int MANT_BITS  = 7;
    localparam int FLOAT_BITS = EXP_BITS + MANT_BITS + 1;

    function automatic int bias_of(input int exp_bits);
        return (1 << (exp_bits - 1)) - 1;
    endfunction

    localparam int BIAS = bias_of(EXP_BITS);

    typedef struct packed {
        logic                 sign;
        logic [EXP_BITS-1:0]  exp;
        logic [MANT_BITS-1:0] mant;
    } float_t;

    localparam float_t FLOAT_INF = '{sign: 1'b0, exp: '1, mant: '0};

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_NORM = 2'd1,
        ST_OUT  = 2'd2
    } expu_acc_state_t;

endpackage

// File: rtl/expu_acc_if.sv
// Input-beat and result handshake bundle of the expu accumulator.
// A beat moves on a clock edge where valid_i && ready_o; a result moves where valid_o && ready_i.
// The producer holds its payload steady while valid is high and unaccepted.
interface expu_acc_if
    import expu_pkg::*;
#(
    parameter int FLOAT_W = FLOAT_BITS
);
    logic               valid_i;
    logic               last_i;
    logic [FLOAT_W-1:0] float_i;
    logic               ready_o;
    logic               valid_o;
    logic               ready_i;
    logic [FLOAT_W-1:0] float_o;
    logic               sat_o;

    modport slave (
        input  valid_i, last_i, float_i, ready_i,
        output ready_o, valid_o, float_o, sat_o
    );

    modport master (
        output valid_i, last_i, float_i, ready_i,
        input  ready_o, valid_o, float_o, sat_o
    );
endinterface

// File: rtl/expu_acc_lzc.sv
// Leading-one detector: index of the most significant set bit, plus an all-zero flag.
module expu_acc_lzc #(
    parameter  int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             zero_o
);
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) idx_o = IDX_W'(i);
        end
    end

    assign zero_o = ~|in_i;
endmodule

// File: rtl/expu_acc.sv
// Saturating fixed-point running sum of bfloat16 beats; on the last beat the sum
// is renormalised to a float and offered on the result handshake.
module expu_acc
    import expu_pkg::*;
#(
    parameter int EXPONENT_BITS = 8,
    parameter int MANTISSA_BITS = 7,
    parameter int ACC_INT_BITS  = 16,
    parameter int ACC_FRAC_BITS = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    expu_acc_if.slave       bus,
    output expu_acc_state_t state_o
);
    localparam int FW     = EXPONENT_BITS + MANTISSA_BITS + 1;
    localparam int ACC_W  = ACC_INT_BITS + ACC_FRAC_BITS;
    localparam int BIAS_P = bias_of(EXPONENT_BITS);
    localparam int SIG_W  = MANTISSA_BITS + 1;
    localparam int WIDE_W = ACC_W + SIG_W;
    localparam int SH_W   = $clog2(WIDE_W);
    localparam int P_W    = $clog2(ACC_W);

    expu_acc_state_t    state_q;
    logic [ACC_W-1:0]   acc_q;
    logic               sat_q;
    logic               norm_phase_q;
    logic [P_W-1:0]     p_q;
    logic               zero_q;
    logic               ready_q;
    logic               valid_q;
    logic [FW-1:0]      float_q;
    logic               sat_out_q;

    logic                     in_sign;
    logic [EXPONENT_BITS-1:0] in_exp;
    logic [MANTISSA_BITS-1:0] in_mant;
    logic [SIG_W-1:0]         sig;
    logic signed [31:0]       sh;
    logic [31:0]              nsh;

    assign {in_sign, in_exp, in_mant} = bus.float_i;
    assign sig = {1'b1, in_mant};
    assign sh  = signed'(32'(in_exp)) - signed'(32'(BIAS_P + MANTISSA_BITS - ACC_FRAC_BITS));
    assign nsh = 32'(-sh);

    logic [WIDE_W-1:0] wide;
    logic [ACC_W-1:0]  conv;
    logic              conv_sat;

    // Beat to fixed point: left shifts that push bits past the accumulator top saturate.
    always_comb begin
        wide     = '0;
        conv     = '0;
        conv_sat = 1'b0;
        if (!in_sign && in_exp != '0) begin
            if (in_exp == '1) begin
                conv_sat = 1'b1;
            end else if (!sh[31]) begin
                if ($unsigned(sh) >= 32'(ACC_W)) begin
                    conv_sat = 1'b1;
                end else begin
                    wide     = WIDE_W'(sig) << sh[SH_W-1:0];
                    conv_sat = |wide[WIDE_W-1:ACC_W];
                    conv     = wide[ACC_W-1:0];
                end
            end else if (nsh <= 32'(MANTISSA_BITS)) begin
                conv = ACC_W'(sig >> nsh[SH_W-1:0]);
            end
        end
    end

    logic [ACC_W:0] sum;
    assign sum = {1'b0, acc_q} + {1'b0, conv};

    logic [P_W-1:0] lzc_idx;
    logic           lzc_zero;

    expu_acc_lzc #(.WIDTH(ACC_W)) u_lzc (
        .in_i   (acc_q),
        .idx_o  (lzc_idx),
        .zero_o (lzc_zero)
    );

    int                       p_int;
    logic [ACC_W-1:0]         aligned;
    logic [EXPONENT_BITS-1:0] norm_exp;
    logic [FW-1:0]            norm_float;

    // Bring the bits just below the leading one down to the mantissa field.
    always_comb begin
        p_int = int'(p_q);
        if (p_int >= MANTISSA_BITS) aligned = acc_q >> (p_int - MANTISSA_BITS);
        else                        aligned = acc_q << (MANTISSA_BITS - p_int);
        norm_exp = EXPONENT_BITS'(p_int - ACC_FRAC_BITS + BIAS_P);
        if (sat_q)       norm_float = {1'b0, {EXPONENT_BITS{1'b1}}, {MANTISSA_BITS{1'b0}}};
        else if (zero_q) norm_float = '0;
        else             norm_float = {1'b0, norm_exp, aligned[MANTISSA_BITS-1:0]};
    end

    // NORM spends two cycles: capture the leading-one position, then build the float.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q      <= ST_ACC;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            norm_phase_q <= 1'b0;
            p_q          <= '0;
            zero_q       <= 1'b1;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            float_q      <= '0;
            sat_out_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (bus.valid_i && ready_q) begin
                        if (conv_sat || sum[ACC_W]) begin
                            acc_q <= '1;
                            sat_q <= 1'b1;
                        end else begin
                            acc_q <= sum[ACC_W-1:0];
                        end
                        if (bus.last_i) begin
                            state_q <= ST_NORM;
                            ready_q <= 1'b0;
                        end
                    end
                end
                ST_NORM: begin
                    if (!norm_phase_q) begin
                        p_q          <= lzc_idx;
                        zero_q       <= lzc_zero;
                        norm_phase_q <= 1'b1;
                    end else begin
                        float_q      <= norm_float;
                        sat_out_q    <= sat_q;
                        valid_q      <= 1'b1;
                        norm_phase_q <= 1'b0;
                        state_q      <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        state_q <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.float_o = float_q;
    assign bus.sat_o   = sat_out_q;
    assign state_o     = state_q;
endmodule
